// File: rtl/seq_detector_param_if.sv
// Stream/config/result bundle for seq_detector_param; master drives the bit stream
// and configuration, slave returns the match flag and saturating match count.
interface seq_detector_param_if #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
);
  logic             en;
  logic             x;
  logic             load;
  logic [PAT_W-1:0] pattern_in;
  logic             overlap_in;
  logic             mealy_in;
  logic             z;
  logic [CNT_W-1:0] match_count;

  modport master (
    output en, x, load, pattern_in, overlap_in, mealy_in,
    input  z, match_count
  );

  modport slave (
    input  en, x, load, pattern_in, overlap_in, mealy_in,
    output z, match_count
  );
endinterface

// File: rtl/seq_detector_param.sv
// Serial pattern detector: Mealy z is same-cycle, Moore z one cycle later; no backpressure,
// a bit is consumed whenever en=1 and load=0, and load always wins over the stream.
module seq_detector_param #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
) (
  input logic                clock,
  input logic                reset,
  seq_detector_param_if.slave sd_if
);
  localparam int               FILL_W  = $clog2(PAT_W + 1);
  localparam logic [PAT_W-1:0] PAT_RST = PAT_W'(4'b1001);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
  localparam logic [FILL_W-1:0] FILL_ARM  = FILL_W'(PAT_W - 1);

  logic [PAT_W-1:0]  r_pattern;
  logic              r_overlap;
  logic              r_mealy;
  logic [PAT_W-1:0]  r_window;
  logic [FILL_W-1:0] r_fill;
  logic [CNT_W-1:0]  r_count;
  logic              r_z;

  logic              w_accept;
  logic              w_match;
  logic [PAT_W-1:0]  w_window_nxt;
  logic [FILL_W-1:0] w_fill_nxt;
  logic [CNT_W-1:0]  w_count_nxt;
  logic              w_z_nxt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pattern <= PAT_RST;
      r_overlap <= 1'b1;
      r_mealy   <= 1'b0;
    end else if (sd_if.load) begin
      r_pattern <= sd_if.pattern_in;
      r_overlap <= sd_if.overlap_in;
      r_mealy   <= sd_if.mealy_in;
    end
  end

  always_comb begin
    w_accept     = sd_if.en && !sd_if.load;
    w_match      = w_accept && (r_fill >= FILL_ARM) &&
                   ({r_window[PAT_W-2:0], sd_if.x} == r_pattern);
    w_window_nxt = r_window;
    w_fill_nxt   = r_fill;
    w_count_nxt  = r_count;
    w_z_nxt      = w_match;

    if (sd_if.load) begin
      w_window_nxt = '0;
      w_fill_nxt   = '0;
      w_count_nxt  = '0;
      w_z_nxt      = 1'b0;
    end else begin
      if (w_match && (r_count != CNT_MAX))
        w_count_nxt = r_count + 1'b1;
      if (w_accept) begin
        // Non-overlapping: a hit consumes its bits, so the next match starts from scratch.
        if (w_match && !r_overlap) begin
          w_window_nxt = '0;
          w_fill_nxt   = '0;
        end else begin
          w_window_nxt = {r_window[PAT_W-2:0], sd_if.x};
          if (r_fill != FILL_FULL)
            w_fill_nxt = r_fill + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_window <= '0;
      r_fill   <= '0;
      r_count  <= '0;
      r_z      <= 1'b0;
    end else begin
      r_window <= w_window_nxt;
      r_fill   <= w_fill_nxt;
      r_count  <= w_count_nxt;
      r_z      <= w_z_nxt;
    end
  end

  assign sd_if.z           = r_mealy ? w_match : r_z;
  assign sd_if.match_count = r_count;
endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: directed vector table, hand-written reset and saturation
// sequences, then random traffic checked against a bit-history reference model.
module tb_seq_detector_param;
  localparam int PW = 4;

  logic clock;
  logic reset;

  seq_detector_param_if #(.PAT_W(PW), .CNT_W(8)) b1 ();
  seq_detector_param_if #(.PAT_W(PW), .CNT_W(2)) b2 ();

  seq_detector_param #(.PAT_W(PW), .CNT_W(8)) u_dut (
    .clock (clock),
    .reset (reset),
    .sd_if (b1)
  );

  seq_detector_param #(.PAT_W(PW), .CNT_W(2)) u_dut_sat (
    .clock (clock),
    .reset (reset),
    .sd_if (b2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic          en;
    logic          x;
    logic          ld;
    logic [PW-1:0] pat;
    logic          ov;
    logic          me;
    logic          ez;
    int            ec;
  } vec_t;

  int tests;
  int fails;

  // Reference: the bits accepted since the last clear, plus the configuration.
  int            hist[$];
  logic [PW-1:0] mpat;
  bit            movl;
  bit            mmeal;
  int            mcnt;
  bit            mprev;

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic en, input logic x, input logic ld,
                              input logic [PW-1:0] pat, input logic ov, input logic me,
                              input logic ez, input int ec);
    vec_t v;
    v.en = en; v.x = x; v.ld = ld; v.pat = pat; v.ov = ov; v.me = me;
    v.ez = ez; v.ec = ec;
    return v;
  endfunction

  function automatic vec_t bit_in(input logic x, input logic ez, input int ec);
    return mk(1'b1, x, 1'b0, '0, 1'b0, 1'b0, ez, ec);
  endfunction

  function automatic vec_t idle(input logic x, input logic ez, input int ec);
    return mk(1'b0, x, 1'b0, '0, 1'b0, 1'b0, ez, ec);
  endfunction

  task automatic model_reset();
    hist.delete();
    mpat  = PW'(4'b1001);
    movl  = 1'b1;
    mmeal = 1'b0;
    mcnt  = 0;
    mprev = 1'b0;
  endtask

  function automatic bit model_match(input logic en, input logic x, input logic ld);
    int v;
    int n;
    if (!en || ld) return 1'b0;
    n = hist.size();
    if (n < PW - 1) return 1'b0;
    v = 0;
    for (int i = n - (PW - 1); i < n; i++) v = (v << 1) | hist[i];
    v = (v << 1) | int'(x);
    return v == int'(mpat);
  endfunction

  task automatic model_step(input vec_t v, input bit m);
    if (v.ld) begin
      mpat  = v.pat;
      movl  = v.ov;
      mmeal = v.me;
      hist.delete();
      mcnt  = 0;
      mprev = 1'b0;
    end else begin
      mprev = m;
      if (m && mcnt < 255) mcnt++;
      if (v.en) begin
        if (m && !movl) hist.delete();
        else begin
          hist.push_back(int'(v.x));
          if (hist.size() > PW) void'(hist.pop_front());
        end
      end
    end
  endtask

  task automatic do_cycle(input vec_t v, input bit use_tbl, input string nm);
    bit m;
    int mz;
    @(posedge clock);
    #1;
    b1.en = v.en; b1.x = v.x; b1.load = v.ld;
    b1.pattern_in = v.pat; b1.overlap_in = v.ov; b1.mealy_in = v.me;
    @(negedge clock);
    m  = model_match(v.en, v.x, v.ld);
    mz = mmeal ? int'(m) : int'(mprev);
    check({nm, "_model_z"}, int'(b1.z), mz);
    check({nm, "_model_cnt"}, int'(b1.match_count), mcnt);
    if (use_tbl) begin
      check({nm, "_z"}, int'(b1.z), int'(v.ez));
      check({nm, "_cnt"}, int'(b1.match_count), v.ec);
    end
    model_step(v, m);
  endtask

  // Called at a falling edge; inputs are parked idle so the edge after release is a hold.
  task automatic pulse_reset();
    b1.en = 1'b0; b1.load = 1'b0;
    reset = 1'b1;
    #1;
    check("rst_cnt", int'(b1.match_count), 0);
    check("rst_z", int'(b1.z), 0);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  vec_t tbl[$];

  initial begin
    vec_t rv;
    int   nm;
    bit   prev_m;
    bit   cur;
    int   pulses;

    tests = 0; fails = 0;
    b1.en = 0; b1.x = 0; b1.load = 0; b1.pattern_in = '0; b1.overlap_in = 0; b1.mealy_in = 0;
    b2.en = 0; b2.x = 0; b2.load = 0; b2.pattern_in = '0; b2.overlap_in = 0; b2.mealy_in = 0;
    reset = 1'b1;
    model_reset();
    #12;
    check("reset_cnt", int'(b1.match_count), 0);
    check("reset_z", int'(b1.z), 0);
    check("reset_sat_cnt", int'(b2.match_count), 0);
    reset = 1'b0;

    // Default config (1001, Moore, overlap): hits on bits 4 and 7.
    tbl.push_back(bit_in(1, 0, 0));
    tbl.push_back(bit_in(0, 0, 0));
    tbl.push_back(bit_in(0, 0, 0));
    tbl.push_back(bit_in(1, 0, 0));
    tbl.push_back(bit_in(0, 1, 1));
    tbl.push_back(bit_in(0, 0, 1));
    tbl.push_back(bit_in(1, 0, 1));
    tbl.push_back(idle(0, 1, 2));
    tbl.push_back(idle(0, 0, 2));
    // Non-overlapping: the shared 1 at bit 4 cannot start the second hit.
    tbl.push_back(mk(1, 0, 1, 4'b1001, 0, 0, 0, 2));
    tbl.push_back(bit_in(1, 0, 0));
    tbl.push_back(bit_in(0, 0, 0));
    tbl.push_back(bit_in(0, 0, 0));
    tbl.push_back(bit_in(1, 0, 0));
    tbl.push_back(bit_in(0, 1, 1));
    tbl.push_back(bit_in(0, 0, 1));
    tbl.push_back(bit_in(1, 0, 1));
    tbl.push_back(idle(0, 0, 1));
    // Mealy 1011: z during the final bit only.
    tbl.push_back(mk(0, 1, 1, 4'b1011, 1, 1, 0, 1));
    tbl.push_back(bit_in(1, 0, 0));
    tbl.push_back(bit_in(0, 0, 0));
    tbl.push_back(bit_in(1, 0, 0));
    tbl.push_back(bit_in(1, 1, 0));
    tbl.push_back(idle(1, 0, 1));
    // Enable gaps: x=1 while en=0 must not disturb 1,0,_,_,_,0,1.
    tbl.push_back(mk(1, 1, 1, 4'b1001, 1, 0, 0, 1));
    tbl.push_back(bit_in(1, 0, 0));
    tbl.push_back(bit_in(0, 0, 0));
    tbl.push_back(idle(1, 0, 0));
    tbl.push_back(idle(1, 0, 0));
    tbl.push_back(idle(1, 0, 0));
    tbl.push_back(bit_in(0, 0, 0));
    tbl.push_back(bit_in(1, 0, 0));
    tbl.push_back(idle(0, 1, 1));
    tbl.push_back(idle(0, 0, 1));

    foreach (tbl[i]) do_cycle(tbl[i], 1'b1, $sformatf("vec%0d", i));

    // Reset in the middle of 1,0,0 must forget the prefix.
    do_cycle(bit_in(1, 0, 1), 1'b1, "mid_a");
    do_cycle(bit_in(0, 0, 1), 1'b1, "mid_b");
    do_cycle(bit_in(0, 0, 1), 1'b1, "mid_c");
    pulse_reset();
    do_cycle(bit_in(1, 0, 0), 1'b1, "mid_d");
    do_cycle(idle(0, 0, 0), 1'b1, "mid_e");
    do_cycle(idle(0, 0, 0), 1'b1, "mid_f");

    for (int n = 0; n < 600; n++) begin
      rv.en  = ($urandom_range(0, 3) != 0);
      rv.x   = 1'($urandom_range(0, 1));
      rv.ld  = ($urandom_range(0, 39) == 0);
      rv.pat = PW'($urandom_range(0, (1 << PW) - 1));
      rv.ov  = 1'($urandom_range(0, 1));
      rv.me  = 1'($urandom_range(0, 1));
      rv.ez  = 1'b0;
      rv.ec  = 0;
      do_cycle(rv, 1'b0, "rand");
      if ($urandom_range(0, 99) == 0) pulse_reset();
    end

    // Saturation with a 2-bit counter: pattern 1010 over ten "10" pairs hits nine times.
    @(posedge clock);
    #1;
    b1.en = 0; b1.load = 0;
    b2.load = 1; b2.pattern_in = 4'b1010; b2.overlap_in = 1; b2.mealy_in = 0;
    prev_m = 1'b0; nm = 0; pulses = 0;
    for (int k = 1; k <= 22; k++) begin
      @(posedge clock);
      #1;
      b2.load = 0;
      b2.en   = (k <= 20);
      b2.x    = (k % 2 == 1);
      @(negedge clock);
      check("sat_z", int'(b2.z), int'(prev_m));
      check("sat_cnt", int'(b2.match_count), (nm > 3) ? 3 : nm);
      pulses += int'(b2.z);
      cur = (k <= 20) && (k >= 4) && (k % 2 == 0);
      if (cur) nm++;
      prev_m = cur;
    end
    check("sat_pulses", pulses, 9);
    check("sat_final_cnt", int'(b2.match_count), 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/seq_detector_param.md
SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 The block SHALL have parameter PAT_W, default 4, meaning pattern length in bits (legal range 2..16).
REQ-002 The block SHALL have parameter CNT_W, default 8, meaning width of the match counter.
REQ-003 The block SHALL have port clock  input  1  rising-edge clock for all state.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port en  input  1  when high, x is sampled as a stream bit this cycle.
REQ-006 The block SHALL have port x  input  1  serial data bit.
REQ-007 The block SHALL have port load  input  1  when high, pattern_in, overlap_in and mealy_in are captured into configuration registers.
REQ-008 The block SHALL have port pattern_in  input  PAT_W  target pattern, MSB = first (oldest) bit.
REQ-009 The block SHALL have port overlap_in  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-010 The block SHALL have port mealy_in  input  1  1 = Mealy output timing, 0 = Moore output timing.
REQ-011 The block SHALL have port z  output  1  match indication.
REQ-012 The block SHALL have port match_count  output  CNT_W  number of matches since reset/load, saturating.

Function
REQ-013 The block SHALL hold window[PAT_W-1:0], a history of accepted bits, shifting left on each accepted bit, new x entering at bit 0.
REQ-014 The block SHALL hold fill, 0..PAT_W, counting accepted bits since the last clear, saturating at PAT_W.
REQ-015 A bit SHALL be accepted on a rising edge when en=1 and load=0; otherwise window, fill and match_count hold.
REQ-016 Match SHALL be defined combinationally as: en=1, load=0, fill>=PAT_W-1, and {window[PAT_W-2:0], x} equals the pattern register.
REQ-017 On an accepted matching bit with overlap=1, window and fill SHALL update normally, so that suffix bits count toward the next match.
REQ-018 On an accepted matching bit with overlap=0, fill SHALL clear to 0 and window SHALL clear to 0, so the next match needs PAT_W fresh bits.
REQ-019 In Mealy mode, z SHALL equal the combinational match, asserted in the same cycle as the final pattern bit.
REQ-020 In Moore mode, z SHALL be a register set to the match value at each rising edge, asserted in the cycle after the final pattern bit and for one cycle per match.
REQ-021 match_count SHALL increment by 1 on each rising edge with match=1, and SHALL hold at 2^CNT_W-1 once it is reached.
REQ-022 On load=1, the block SHALL capture the pattern, overlap and mealy registers, clear window, fill, match_count and the Moore z register, and ignore x in that cycle.
REQ-023 When load and en are both high, load SHALL win.
REQ-024 A mode change SHALL take effect only through load; the z timing mode SHALL switch on the cycle after load.
REQ-025 With en=0, z SHALL be 0 in Mealy mode; in Moore mode z SHALL fall to 0 at the next edge.

Reset
REQ-026 Reset SHALL asynchronously clear window, fill, match_count and the Moore z register to 0.
REQ-027 Reset SHALL set the pattern register to PAT_W'b1001 padded with zeros at the MSB (for the default, 1001), overlap to 1, and mealy to 0.
REQ-028 A reset asserted mid-sequence SHALL discard all partial history; after release, a full PAT_W bits SHALL be required before any match.

Verification
REQ-029 Test 1 (PAT_W=4, default config, Moore/overlap) -- stimulus: x stream 1,0,0,1,0,0,1 with en=1 -> required response: z high in the cycles after bits 4 and 7, match_count=2.
REQ-030 Test 2 (same stream, load overlap_in=0, pattern 1001) -> required response: only the match at bit 4, match_count=1.
REQ-031 Test 3 (Mealy, pattern 1011) -- stimulus: stream 1,0,1,1 -> required response: z high combinationally during bit 4, low after it.
REQ-032 Test 4 (en gaps) -- stimulus: 1,0,[en=0 for 3 cycles],0,1 with pattern 1001 -> required response: a single match; x is ignored while en=0.
REQ-033 Test 5 (reset mid-operation) -- stimulus: 1,0,0, reset pulse, then 1 -> required response: no match; match_count=0.
REQ-034 Test 6 (saturation, CNT_W=2, overlap, pattern 1010) -- stimulus: ten repetitions of 10 -> required response: match_count stops at 3; z keeps pulsing.
